// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10, one per valid/ready handshake.
// Optional build macro KEY_STORE_EN adds an 11-entry round-key store readable via rd_addr.
module aes_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rk_ready,
  input  logic [3:0]   rd_addr,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   rnd_idx,
  output logic         rk_last,
  output logic         busy,
  output logic [127:0] rd_key
);

  // FIPS-197 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b sits at bit offset (255-b)*8 = {~b, 3'b000}.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    sub_byte = SBOX[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q;
  logic [7:0]   rcon_q;
  logic         rk_valid_q;
  logic [127:0] round_key_q;
  logic [3:0]   rnd_idx_q;
  logic         rk_last_q;

  logic [31:0]  w0, w1, w2, w3, t_word, n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [7:0]   rcon_next;
  logic         handshake;

  always_comb begin
    w0        = round_key_q[127:96];
    w1        = round_key_q[95:64];
    w2        = round_key_q[63:32];
    w3        = round_key_q[31:0];
    // SubWord(RotWord(w3)) with the round constant folded into the top byte.
    t_word    = {sub_byte(w3[23:16]) ^ rcon_q, sub_byte(w3[15:8]),
                 sub_byte(w3[7:0]), sub_byte(w3[31:24])};
    n0        = w0 ^ t_word;
    n1        = n0 ^ w1;
    n2        = n1 ^ w2;
    n3        = n2 ^ w3;
    next_key  = {n0, n1, n2, n3};
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  assign handshake = rk_valid_q & rk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rcon_q      <= 8'h01;
      rk_valid_q  <= 1'b0;
      round_key_q <= '0;
      rnd_idx_q   <= '0;
      rk_last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            round_key_q <= key;
            rnd_idx_q   <= 4'd0;
            rcon_q      <= 8'h01;
            rk_valid_q  <= 1'b1;
            rk_last_q   <= 1'b0;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            if (rnd_idx_q == 4'd10) begin
              rk_valid_q <= 1'b0;
              rk_last_q  <= 1'b0;
              state_q    <= IDLE;
            end else begin
              round_key_q <= next_key;
              rnd_idx_q   <= rnd_idx_q + 4'd1;
              rcon_q      <= rcon_next;
              rk_last_q   <= (rnd_idx_q == 4'd9);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk_valid  = rk_valid_q;
  assign round_key = round_key_q;
  assign rnd_idx   = rnd_idx_q;
  assign rk_last   = rk_last_q;
  assign busy      = (state_q == RUN);

`ifdef KEY_STORE_EN
  logic [127:0] store_q [11];

  // Rewriting the visible slot every valid cycle is harmless and avoids tracking handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) store_q[i] <= '0;
    end else if (rk_valid_q && (rnd_idx_q <= 4'd10)) begin
      store_q[rnd_idx_q] <= round_key_q;
    end
  end

  assign rd_key = (rd_addr <= 4'd10) ? store_q[rd_addr] : '0;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_key         = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-schedule vectors.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_aes_key_expand;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic [3:0]   rd_addr;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   rnd_idx;
  logic         rk_last;
  logic         busy;
  logic [127:0] rd_key;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic [127:0] exp_q[$];

  aes_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .rk_ready  (rk_ready),
    .rd_addr   (rd_addr),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .rnd_idx   (rnd_idx),
    .rk_last   (rk_last),
    .busy      (busy),
    .rd_key    (rd_key)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; key = '0; rk_ready = 1'b0; rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rk_valid, rnd_idx, rk_last, busy} !== 7'd0 || round_key !== '0 || rd_key !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b idx=%0d last=%b busy=%b key=%h rd=%h exp all zero",
               rk_valid, rnd_idx, rk_last, busy, round_key, rd_key);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips_sequence();
    key = KEY_A; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      n_checks++;
      if (rk_valid !== 1'b1 || rnd_idx !== 4'(k) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL fips_ctrl k=%0d: valid=%b idx=%0d busy=%b exp 1/%0d/1", k, rk_valid, rnd_idx, busy, k);
      end
      n_checks++;
      if (round_key !== exp_q[k]) begin
        n_fail++;
        $display("FAIL fips_key k=%0d: got %h exp %h", k, round_key, exp_q[k]);
      end
      n_checks++;
      if (rk_last !== (k == 10)) begin
        n_fail++;
        $display("FAIL fips_last k=%0d: got %b exp %b", k, rk_last, (k == 10));
      end
      @(negedge clk);
    end
    n_checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_last !== 1'b0 || rnd_idx !== 4'd10 || round_key !== exp_q[10]) begin
      n_fail++;
      $display("FAIL fips_done: valid=%b busy=%b last=%b idx=%0d key=%h exp 0/0/0/10/%h",
               rk_valid, busy, rk_last, rnd_idx, round_key, exp_q[10]);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_random_stall();
    int hs;
    int cyc;
    logic rdy;
    key = KEY_A; start = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 11 && cyc < 400) begin
      n_checks++;
      if (rk_valid !== 1'b1 || rnd_idx !== 4'(hs) || round_key !== exp_q[hs]) begin
        n_fail++;
        $display("FAIL stall_seq hs=%0d: valid=%b idx=%0d key=%h exp 1/%0d/%h",
                 hs, rk_valid, rnd_idx, round_key, hs, exp_q[hs]);
      end
      rdy = 1'($urandom_range(0, 1));
      rk_ready = rdy;
      @(negedge clk);
      if (rdy) hs++;
      cyc++;
    end
    n_checks++;
    if (hs != 11) begin
      n_fail++;
      $display("FAIL stall_timeout: handshakes %0d exp 11", hs);
    end
    rk_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_count: valid=%b busy=%b after 11 handshakes exp 0/0", rk_valid, busy);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    key = KEY_A; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      start = (k == 3);
      if (k == 3) key = KEY_B;
      n_checks++;
      if (rk_valid !== 1'b1 || rnd_idx !== 4'(k) || round_key !== exp_q[k]) begin
        n_fail++;
        $display("FAIL ignore_start k=%0d: valid=%b idx=%0d key=%h exp 1/%0d/%h",
                 k, rk_valid, rnd_idx, round_key, k, exp_q[k]);
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_done: busy=%b valid=%b exp 0/0", busy, rk_valid);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    key = KEY_A; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rk_valid !== 1'b1 || rnd_idx !== 4'd5 || round_key !== exp_q[5]) begin
      n_fail++;
      $display("FAIL mid_stall_hold: valid=%b idx=%0d key=%h exp 1/5/%h", rk_valid, rnd_idx, round_key, exp_q[5]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rk_valid, rnd_idx, rk_last, busy} !== 7'd0 || round_key !== '0 || rd_key !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b idx=%0d last=%b busy=%b key=%h rd=%h exp all zero",
               rk_valid, rnd_idx, rk_last, busy, round_key, rd_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_resume: busy=%b valid=%b exp 0/0", busy, rk_valid);
    end
    key = KEY_A; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      n_checks++;
      if (rk_valid !== 1'b1 || rnd_idx !== 4'(k) || round_key !== exp_q[k]) begin
        n_fail++;
        $display("FAIL after_reset k=%0d: valid=%b idx=%0d key=%h exp 1/%0d/%h",
                 k, rk_valid, rnd_idx, round_key, k, exp_q[k]);
      end
      @(negedge clk);
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_key_store();
`ifdef KEY_STORE_EN
    for (int a = 0; a <= 10; a++) begin
      rd_addr = 4'(a);
      #1;
      n_checks++;
      if (rd_key !== exp_q[a]) begin
        n_fail++;
        $display("FAIL store_read addr=%0d: got %h exp %h", a, rd_key, exp_q[a]);
      end
    end
    for (int a = 11; a <= 15; a++) begin
      rd_addr = 4'(a);
      #1;
      n_checks++;
      if (rd_key !== '0) begin
        n_fail++;
        $display("FAIL store_oob addr=%0d: got %h exp 0", a, rd_key);
      end
    end
`else
    for (int a = 0; a <= 15; a++) begin
      rd_addr = 4'(a);
      #1;
      n_checks++;
      if (rd_key !== '0) begin
        n_fail++;
        $display("FAIL no_store addr=%0d: got %h exp 0", a, rd_key);
      end
    end
`endif
    rd_addr = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    key = KEY_A; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    key = KEY_B;
    for (int k = 0; k <= 10; k++) begin
      n_checks++;
      if (rk_valid !== 1'b1 || rnd_idx !== 4'(k) || round_key !== exp_q[k]) begin
        n_fail++;
        $display("FAIL b2b_first k=%0d: valid=%b idx=%0d key=%h exp 1/%0d/%h",
                 k, rk_valid, rnd_idx, round_key, k, exp_q[k]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: valid=%b busy=%b exp 0/0", rk_valid, busy);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (rk_valid !== 1'b1 || busy !== 1'b1 || rnd_idx !== 4'd0 || round_key !== KEY_B) begin
      n_fail++;
      $display("FAIL b2b_second_idx0: valid=%b busy=%b idx=%0d key=%h exp 1/1/0/%h",
               rk_valid, busy, rnd_idx, round_key, KEY_B);
    end
    @(negedge clk);
    n_checks++;
    if (rnd_idx !== 4'd1 || round_key !== KEY_B_R1) begin
      n_fail++;
      $display("FAIL b2b_second_idx1: idx=%0d key=%h exp 1/%h", rnd_idx, round_key, KEY_B_R1);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (busy !== 1'b0 || cyc != 10) begin
      n_fail++;
      $display("FAIL b2b_drain: busy=%b cycles=%0d exp 0/10", busy, cyc);
    end
    rk_ready = 1'b0;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    exp_q.push_back(KEY_A);
    exp_q.push_back(128'ha0fafe1788542cb123a339392a6c7605);
    exp_q.push_back(128'hf2c295f27a96b9435935807a7359f67f);
    exp_q.push_back(128'h3d80477d4716fe3e1e237e446d7a883b);
    exp_q.push_back(128'hef44a541a8525b7fb671253bdb0bad00);
    exp_q.push_back(128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    exp_q.push_back(128'h6d88a37a110b3efddbf98641ca0093fd);
    exp_q.push_back(128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
    exp_q.push_back(128'head27321b58dbad2312bf5607f8d292f);
    exp_q.push_back(128'hac7766f319fadc2128d12941575c006e);
    exp_q.push_back(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    test_reset();
    test_fips_sequence();
    test_key_store();
    test_random_stall();
    test_start_ignored();
    test_reset_mid_stall();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
